// File: rtl/int_divider_pkg.sv
// Shared definitions for the 2432 execute-stage divider: opcodes, FSM states, width.
package int_divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [0:0] {
        DIV,
        DIVS
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_FIX
    } div_state_e;

endpackage

// File: rtl/int_divider_div_step.sv
// One combinational restoring-division step: shift in the dividend MSB, trial-subtract.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // 33-bit trial subtraction; the top bit is the borrow, so r' >= b exactly when it is clear
    assign w_shift = {i_rem, i_msb};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_qbit  = ~w_diff[WIDTH];
    assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/int_divider.sv
// Iterative signed/unsigned divider: one restoring step per clock, sign fix in a final cycle.
module int_divider
    import int_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             vout
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    div_state_e       r_state, w_next;
    logic             w_accept;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_q_neg, r_r_neg, r_ovf, r_bypass;
    logic             r_busy, r_done, r_dbz, r_vout;
    logic [WIDTH-1:0] r_quotient, r_remainder;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_qbit;
    logic             w_b_zero;

    assign w_b_zero = (din_b == '0);
    assign w_a_mag  = (signed_op && din_a[WIDTH-1]) ? -din_a : din_a;
    assign w_b_mag  = (signed_op && din_b[WIDTH-1]) ? -din_b : din_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_msb     (r_acc[WIDTH-1]),
        .i_divisor (r_div),
        .o_rem     (w_step_rem),
        .o_qbit    (w_qbit)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = w_b_zero ? DIV_FIX : DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (r_cnt == CW'(WIDTH - 1)) w_next = DIV_FIX;
            end
            DIV_FIX:  w_next = DIV_IDLE;
            default:  w_next = DIV_IDLE;
        endcase
    end

    // r_acc holds the dividend on accept and fills with quotient bits as it shifts out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= DIV_IDLE;
            r_acc       <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_ovf       <= 1'b0;
            r_bypass    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_vout      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_busy   <= 1'b1;
                        r_dbz    <= 1'b0;
                        r_vout   <= 1'b0;
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_bypass <= w_b_zero;
                        r_acc    <= w_b_zero ? din_a : w_a_mag;
                        r_div    <= w_b_mag;
                        r_q_neg  <= signed_op & (din_a[WIDTH-1] ^ din_b[WIDTH-1]);
                        r_r_neg  <= signed_op & din_a[WIDTH-1];
                        r_ovf    <= signed_op && (din_a == {1'b1, {(WIDTH-1){1'b0}}})
                                    && (din_b == '1);
                    end
                end
                DIV_RUN: begin
                    r_rem <= w_step_rem;
                    r_acc <= {r_acc[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + CW'(1);
                end
                DIV_FIX: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (r_bypass) begin
                        r_quotient  <= '1;
                        r_remainder <= r_acc;
                        r_dbz       <= 1'b1;
                        r_vout      <= 1'b0;
                    end else begin
                        r_quotient  <= r_q_neg ? -r_acc : r_acc;
                        r_remainder <= r_r_neg ? -r_rem : r_rem;
                        r_dbz       <= 1'b0;
                        r_vout      <= r_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dbz       = r_dbz;
    assign vout      = r_vout;

endmodule

// File: tb/tb_int_divider.sv
// Self-checking bench for int_divider: vector table, random model vectors, corner sequences.
module tb_int_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] din_a, din_b;
    logic        busy, done, dbz, vout;
    logic [31:0] quotient, remainder;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[11];

    int_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .din_a     (din_a),
        .din_b     (din_b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .vout      (vout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model built on SystemVerilog's own 64-bit arithmetic
    function automatic vec_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        vec_t   v;
        longint sa, sb, sq, sr;
        v.s = s; v.a = a; v.b = b; v.dz = 1'b0; v.ov = 1'b0;
        if (b == 32'd0) begin
            v.q = 32'hFFFF_FFFF; v.r = a; v.dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            sq = sa / sb; sr = sa % sb;
            v.q = sq[31:0]; v.r = sr[31:0];
            v.ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end else begin
            v.q = a / b; v.r = a % b;
        end
        return v;
    endfunction

    task automatic compare_result(input string tag);
        vec_t e;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, " quotient"},  quotient,  e.q);
        check({tag, " remainder"}, remainder, e.r);
        check({tag, " dbz"},       {31'd0, dbz},  {31'd0, e.dz});
        check({tag, " vout"},      {31'd0, vout}, {31'd0, e.ov});
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int n, busy_err, exp_lat;
        bit got;
        exp_lat = (v.b == 32'd0) ? 1 : 33;
        sb_q.push_back(v);
        @(negedge clk);
        start = 1'b1; signed_op = v.s; din_a = v.a; din_b = v.b;
        @(posedge clk); #1;
        start = 1'b0; din_a = $urandom; din_b = $urandom; signed_op = $urandom_range(0, 1);
        check({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
        n = 0; busy_err = 0; got = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (done) begin got = 1; break; end
            if (!busy) busy_err++;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " busy dropped early"}, busy_err, 32'd0);
        if (got) begin
            compare_result(tag);
            check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            check({tag, " done width"}, {31'd0, done}, 32'd0);
        end else begin
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ndone, first, busy_err;
        vec_t v;

        tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1, 1'b0};
        tbl[4]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 1'b0};
        tbl[5]  = '{1'b0, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1};
        tbl[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
        tbl[8]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; signed_op = 1'b0; din_a = '0; din_b = '0;
        #12;
        check("reset outputs", {28'd0, busy, done, dbz, vout}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 11; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            v = model(1'(i % 2), $urandom, (i == 4) ? 32'd0 : ($urandom >> $urandom_range(0, 28)));
            run_op(v, $sformatf("rnd%0d", i));
        end

        // start pulsed again while busy must be ignored
        sb_q.push_back(model(1'b0, 32'd50, 32'd5));
        @(negedge clk); start = 1'b1; signed_op = 1'b0; din_a = 32'd50; din_b = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        n = 0; ndone = 0; first = 0; busy_err = 0;
        while (n < 80) begin
            @(posedge clk); #1;
            n++;
            if (n == 10) begin start = 1'b1; din_a = 32'd8; din_b = 32'd2; end
            if (n == 11) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin first = n; compare_result("busy-start"); end
            end
            if (ndone == 0 && !busy) busy_err++;
        end
        check("busy-start done count", ndone, 32'd1);
        check("busy-start latency", first, 32'd33);
        check("busy-start busy dropped early", busy_err, 32'd0);

        // asynchronous reset mid-operation
        @(negedge clk); start = 1'b1; signed_op = 1'b0; din_a = 32'd1000; din_b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 15; i++) begin @(posedge clk); #1; end
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midreset outputs", {28'd0, busy, done, dbz, vout}, 32'd0);
        check("midreset quotient", quotient, 32'd0);
        check("midreset remainder", remainder, 32'd0);
        @(negedge clk); @(negedge clk); reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done || busy) ndone++; end
        check("post-reset idle", ndone, 32'd0);
        run_op(model(1'b0, 32'd20, 32'd6), "after-reset");

        // start held high: back-to-back operations every 34 cycles
        sb_q.push_back(model(1'b0, 32'd9, 32'd3));
        sb_q.push_back(model(1'b0, 32'd9, 32'd3));
        @(negedge clk); start = 1'b1; signed_op = 1'b0; din_a = 32'd9; din_b = 32'd3;
        @(posedge clk); #1;
        n = 0; ndone = 0; first = 0;
        while (n < 150 && ndone < 2) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                ndone++;
                compare_result($sformatf("b2b%0d", ndone));
                if (ndone == 1) first = n;
                else begin
                    start = 1'b0;
                    check("b2b period", n - first, 32'd34);
                end
            end
        end
        start = 1'b0;
        check("b2b first latency", first, 32'd33);
        check("b2b done count", ndone, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
